// File: rtl/cache_load_ctrl.sv
// cache_load_ctrl: pops 32-bit words from the input word buffer, packs them
// into WPL-word cache lines and issues one line-write per line, advancing the
// line address by WPL words each time (wrapping mod 2^ADDR_W).
//
// Optional feature macro: CACHE_LOAD_CHECKSUM_EN
//   defined   -> extra output checksum[31:0], the mod-2^32 sum of every word
//                popped since the last accepted start (stable from done on).
//   undefined -> checksum port and adder are absent.
//
// Handshakes:
//   buffer side: a word moves when buf_pop is high at a rising clk edge;
//                buf_pop = buf_valid & (block in FILL) & (words remaining),
//                so buf_valid may drop at any time and simply stalls FILL.
//   cache side : cache_req rises with addr/line/wmask and all four are held
//                stable until a clk edge sees cache_ack high; cache_ack is
//                ignored whenever cache_req is low.
module cache_load_ctrl #(
  parameter int WPL    = 4,
  parameter int ADDR_W = 27,
  parameter int LEN_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [LEN_W-1:0]    num_words,
  input  logic                buf_valid,
  input  logic [31:0]         buf_data,
  output logic                buf_pop,
  output logic                cache_req,
  output logic [ADDR_W-1:0]   cache_addr,
  output logic [32*WPL-1:0]   cache_line,
  output logic [WPL-1:0]      cache_wmask,
  input  logic                cache_ack,
  output logic                busy,
  output logic                done,
  output logic [1:0]          state_dbg
`ifdef CACHE_LOAD_CHECKSUM_EN
  ,
  output logic [31:0]         checksum
`endif
);

  localparam int SW = $clog2(WPL);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  remaining;
  logic [SW-1:0]     slot;

  // A word is consumed only while filling and only if the load still needs one.
  assign buf_pop   = (state == FILL) && buf_valid && (remaining != '0);
  assign state_dbg = state;

  // Load sequencer: state, line assembly, address advance and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cache_req   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cache_wmask <= '0;
      cache_line  <= '0;
      cache_addr  <= '0;
      remaining   <= '0;
      slot        <= '0;
`ifdef CACHE_LOAD_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Low address bits are forced to zero so every line is aligned.
            cache_addr <= {base_addr[ADDR_W-1:SW], {SW{1'b0}}};
            remaining  <= num_words;
            slot       <= '0;
            busy       <= 1'b1;
`ifdef CACHE_LOAD_CHECKSUM_EN
            checksum   <= '0;
`endif
            if (num_words == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end

        FILL: begin
          if (buf_pop) begin
            cache_line[32*slot +: 32] <= buf_data;
            cache_wmask[slot]         <= 1'b1;
            slot                      <= slot + 1'b1;
            remaining                 <= remaining - 1'b1;
`ifdef CACHE_LOAD_CHECKSUM_EN
            checksum                  <= checksum + buf_data;
`endif
            // Line full, or this was the final word (partial last line).
            if (slot == SW'(WPL - 1) || remaining == LEN_W'(1)) begin
              state     <= WRITE;
              cache_req <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (cache_ack) begin
            cache_req   <= 1'b0;
            cache_line  <= '0;
            cache_wmask <= '0;
            slot        <= '0;
            cache_addr  <= cache_addr + ADDR_W'(WPL);
            if (remaining == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state <= FILL;
            end
          end
        end

        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_load_ctrl.sv
// tb_cache_load_ctrl: directed bench for cache_load_ctrl. A buffer model
// feeds words from src_q, a cache model acknowledges line writes after a
// programmable delay and checks each accepted line against exp_q.
module tb_cache_load_ctrl;

  localparam int WPL    = 4;
  localparam int ADDR_W = 27;
  localparam int LEN_W  = 16;
  localparam int EW     = ADDR_W + 32*WPL + WPL;

  // ---------------- clock / reset / DUT ----------------
  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [LEN_W-1:0]    num_words = '0;
  logic                buf_valid = 1'b0;
  logic [31:0]         buf_data = '0;
  logic                buf_pop;
  logic                cache_req;
  logic [ADDR_W-1:0]   cache_addr;
  logic [32*WPL-1:0]   cache_line;
  logic [WPL-1:0]      cache_wmask;
  logic                cache_ack = 1'b0;
  logic                busy;
  logic                done;
  logic [1:0]          state_dbg;
`ifdef CACHE_LOAD_CHECKSUM_EN
  logic [31:0]         checksum;
`endif

  always #5 clk = ~clk;

  cache_load_ctrl #(.WPL(WPL), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_words(num_words), .buf_valid(buf_valid), .buf_data(buf_data),
    .buf_pop(buf_pop), .cache_req(cache_req), .cache_addr(cache_addr),
    .cache_line(cache_line), .cache_wmask(cache_wmask), .cache_ack(cache_ack),
    .busy(busy), .done(done), .state_dbg(state_dbg)
`ifdef CACHE_LOAD_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   src_q[$];
  logic [31:0]   exp_sum;
  bit  toggle_mode = 1'b0;
  bit  phase = 1'b0;
  bit  pop_pending = 1'b0;
  int  ack_delay = 1;
  int  pop_cnt = 0;
  int  line_cnt = 0;
  int  done_cnt = 0;
  int  pop_in_write = 0;
  int  stable_err = 0;
  bit  in_req = 1'b0;
  bit  ack_sent = 1'b0;
  int  wait_cnt = 0;
  logic [EW-1:0] snap;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- buffer driver ----------------
  // A pop seen before an edge retires the head word after that edge.
  always @(posedge clk) begin
    pop_pending <= buf_pop && !rst;
    if (buf_pop && cache_req) pop_in_write++;
  end

  always @(negedge clk) begin
    logic [31:0] tmp;
    if (pop_pending) begin
      if (src_q.size() > 0) tmp = src_q.pop_front();
      pop_cnt++;
    end
    phase     = !phase;
    buf_valid = (src_q.size() > 0) && (!toggle_mode || phase);
    buf_data  = buf_valid ? src_q[0] : 32'hDEAD_BEEF;
  end

  // ---------------- cache responder + scoreboard compare ----------------
  always @(negedge clk) begin
    logic [EW-1:0] cur;
    cache_ack = 1'b0;
    cur = {cache_addr, cache_line, cache_wmask};
    if (cache_req && !ack_sent) begin
      if (!in_req) begin
        in_req   = 1'b1;
        snap     = cur;
        wait_cnt = ack_delay;
      end else begin
        if (cur !== snap) stable_err++;
        if (wait_cnt > 0) wait_cnt--;
      end
      if (wait_cnt == 0) begin
        cache_ack = 1'b1;
        ack_sent  = 1'b1;
        line_cnt++;
        if (exp_q.size() == 0) check("sb_unexpected_line", 1, 0);
        else check("sb_line", cur, exp_q.pop_front());
      end
    end else if (!cache_req) begin
      in_req   = 1'b0;
      ack_sent = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // ---------------- stimulus helpers ----------------
  task automatic setup_load(input logic [ADDR_W-1:0] base, input int n, input int extra, input bit seq);
    logic [ADDR_W-1:0]  a;
    logic [32*WPL-1:0]  line;
    logic [WPL-1:0]     m;
    logic [31:0]        w;
    a = base;
    a[1:0] = 2'b00;
    line = '0;
    m = '0;
    exp_sum = '0;
    for (int i = 0; i < n; i++) begin
      w = seq ? 32'(i + 1) : $urandom;
      src_q.push_back(w);
      exp_sum += w;
      line[32*(i % WPL) +: 32] = w;
      m[i % WPL] = 1'b1;
      if ((i % WPL) == WPL - 1 || i == n - 1) begin
        exp_q.push_back({a, line, m});
        a = a + ADDR_W'(WPL);
        line = '0;
        m = '0;
      end
    end
    for (int i = 0; i < extra; i++) src_q.push_back($urandom);
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] base, input int n);
    @(negedge clk);
    base_addr = base;
    num_words = LEN_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      if (done) seen = 1'b1;
      else @(negedge clk);
    end
    check(tag, seen, 1);
  endtask

  // Runs one complete load and checks its bookkeeping after completion.
  task automatic run_load(input string tag, input logic [ADDR_W-1:0] base, input int n,
                          input int extra, input bit seq, input int lines);
    int p0, l0, d0;
    p0 = pop_cnt; l0 = line_cnt; d0 = done_cnt;
    setup_load(base, n, extra, seq);
    do_start(base, n);
    wait_done({tag, "_done"});
    check({tag, "_busy_at_done"}, busy, 1);
`ifdef CACHE_LOAD_CHECKSUM_EN
    check({tag, "_checksum"}, checksum, exp_sum);
`endif
    @(negedge clk);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_done_low"}, done, 0);
    repeat (3) @(negedge clk);
    check({tag, "_pops"}, pop_cnt - p0, n);
    check({tag, "_lines"}, line_cnt - l0, lines);
    check({tag, "_done_pulses"}, done_cnt - d0, 1);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    src_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int p0, l0, d0;
    bit seen;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req", cache_req, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wmask", cache_wmask, 0);
    check("rst_line", cache_line, 0);
    check("rst_addr", cache_addr, 0);
    check("rst_state", state_dbg, 0);
`ifdef CACHE_LOAD_CHECKSUM_EN
    check("rst_checksum", checksum, 0);
`endif

    // 1: two full lines, ack one cycle after request
    ack_delay = 1;
    run_load("t1", 27'h100, 8, 0, 1'b0, 2);

    // 2: partial last line, extra words in the buffer must stay unpopped
    run_load("t2", 27'h200, 6, 3, 1'b0, 2);

    // 3: zero-length load
    p0 = pop_cnt; l0 = line_cnt; d0 = done_cnt;
    src_q.push_back(32'h1234_5678);
    src_q.push_back(32'h9ABC_DEF0);
    do_start(27'h300, 0);
    check("t3_done_cycle2", done, 1);
    @(negedge clk);
    check("t3_done_low", done, 0);
    check("t3_busy_low", busy, 0);
    repeat (3) @(negedge clk);
    check("t3_pops", pop_cnt - p0, 0);
    check("t3_lines", line_cnt - l0, 0);
    check("t3_done_pulses", done_cnt - d0, 1);
    src_q.delete();

    // 4: stalling buffer, slow ack, start pulse while busy must be ignored
    toggle_mode = 1'b1;
    ack_delay = 5;
    stable_err = 0;
    pop_in_write = 0;
    p0 = pop_cnt; l0 = line_cnt; d0 = done_cnt;
    setup_load(27'h43, 8, 0, 1'b0);
    do_start(27'h43, 8);
    repeat (3) @(negedge clk);
    base_addr = 27'h7000;
    num_words = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    check("t4_pops", pop_cnt - p0, 8);
    check("t4_lines", line_cnt - l0, 2);
    check("t4_done_pulses", done_cnt - d0, 1);
    check("t4_exp_empty", exp_q.size(), 0);
    check("t4_req_stable", stable_err, 0);
    check("t4_pop_in_write", pop_in_write, 0);
    toggle_mode = 1'b0;
    src_q.delete();

    // 5: reset while a line write is pending
    ack_delay = 30;
    setup_load(27'h500, 8, 0, 1'b0);
    do_start(27'h500, 8);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (cache_req) seen = 1'b1;
      else @(negedge clk);
    end
    check("t5_req_seen", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_req_after_rst", cache_req, 0);
    check("t5_busy_after_rst", busy, 0);
    p0 = pop_cnt;
    repeat (4) @(negedge clk);
    check("t5_no_pop_after_rst", pop_cnt - p0, 0);
    check("t5_state_idle", state_dbg, 0);
    src_q.delete();
    exp_q.delete();
    ack_delay = 1;
    run_load("t5b", 27'h300, 4, 0, 1'b0, 1);

    // 6: words 1..8 and address wrap at the top of the address space
    run_load("t6", 27'h7FF_FFFC, 8, 0, 1'b1, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute bound so the run always ends even if the DUT wedges.
  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
